// File: rtl/axi_slave_pkg.sv
// Shared types and helpers for the AXI4 memory responder.
//   axi_burst_e  : AxBURST encodings (FIXED/INCR/WRAP; 2'b11 is reserved)
//   OKAY/SLVERR  : xRESP codes
//   wr_state_e   : write-channel FSM states
//   rd_state_e   : read-channel FSM states
//   next_addr()  : per-beat address step for FIXED/INCR bursts
package axi_slave_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } axi_burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Computed at full 64-bit width; the caller truncates to its address width,
  // which gives the modulo-2^ADDR_WIDTH wrap of INCR bursts for free.
  function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                            input logic [7:0]  size,
                                            input logic [1:0]  burst);
    logic [63:0] step;
    step = 64'd1 << size;
    if (burst == INCR) return addr + step;
    return addr;
  endfunction

endpackage

// File: rtl/axi_slave_ram.sv
// Word-addressed RAM behind the AXI responder.
//   clk   : clock
//   we    : write enable (one word per cycle)
//   waddr : write word index
//   wstrb : byte-lane enables for the write
//   wdata : write data
//   raddr : read word index (asynchronous read)
//   rdata : word at raddr
// The read port is combinational, so a read registered on the same edge as a
// write to the same word sees the pre-write contents.
module axi_slave_ram
  import axi_slave_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(MEM_DEPTH),
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 memory responder: one write burst and one read burst in flight at a
// time, the two directions independent of each other.
//   axi_ACLK / axi_ARESETn        : clock, asynchronous active-low reset
//   axi_AW* / axi_W* / axi_B*     : write request, write data, write response
//   axi_AR* / axi_R*              : read request, read data
//   wr_beat_num                   : W beats accepted in the current burst
//   next_rd_beat_num              : index of the beat currently on R
//   latched_awlen / latched_arlen : AxLEN captured at the request handshake
// Malformed requests (WRAP/reserved burst, SIZE wider than the bus) answer
// SLVERR and never touch the RAM; a WLAST in the wrong place only flags
// SLVERR, the beats are still written.
module axi_slave_mem
  import axi_slave_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int LEN_WIDTH    = 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int BURST_WIDTH  = 2,
  parameter int RESP_WIDTH   = 2,
  parameter int ID_WIDTH     = 4,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH    = 1024
) (
  input  logic                    axi_ACLK,
  input  logic                    axi_ARESETn,
  input  logic                    axi_AWVALID,
  output logic                    axi_AWREADY,
  input  logic [ID_WIDTH-1:0]     axi_AWID,
  input  logic [ADDR_WIDTH-1:0]   axi_AWADDR,
  input  logic [LEN_WIDTH-1:0]    axi_AWLEN,
  input  logic [SIZE_WIDTH-1:0]   axi_AWSIZE,
  input  logic [BURST_WIDTH-1:0]  axi_AWBURST,
  input  logic                    axi_WVALID,
  output logic                    axi_WREADY,
  input  logic [DATA_WIDTH-1:0]   axi_WDATA,
  input  logic [STROBE_WIDTH-1:0] axi_WSTRB,
  input  logic                    axi_WLAST,
  output logic                    axi_BVALID,
  input  logic                    axi_BREADY,
  output logic [ID_WIDTH-1:0]     axi_BID,
  output logic [RESP_WIDTH-1:0]   axi_BRESP,
  input  logic                    axi_ARVALID,
  output logic                    axi_ARREADY,
  input  logic [ID_WIDTH-1:0]     axi_ARID,
  input  logic [ADDR_WIDTH-1:0]   axi_ARADDR,
  input  logic [LEN_WIDTH-1:0]    axi_ARLEN,
  input  logic [SIZE_WIDTH-1:0]   axi_ARSIZE,
  input  logic [BURST_WIDTH-1:0]  axi_ARBURST,
  output logic                    axi_RVALID,
  input  logic                    axi_RREADY,
  output logic [ID_WIDTH-1:0]     axi_RID,
  output logic [DATA_WIDTH-1:0]   axi_RDATA,
  output logic [RESP_WIDTH-1:0]   axi_RRESP,
  output logic                    axi_RLAST,
  output logic [31:0]             wr_beat_num,
  output logic [31:0]             next_rd_beat_num,
  output logic [LEN_WIDTH-1:0]    latched_awlen,
  output logic [LEN_WIDTH-1:0]    latched_arlen
);

  localparam int LSB   = $clog2(STROBE_WIDTH);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  wr_state_e wr_state, wr_state_nxt;
  rd_state_e rd_state, rd_state_nxt;

  logic                   aw_hs, w_hs, ar_hs, r_hs;
  logic                   aw_bad, ar_bad;
  logic                   w_last_beat;
  logic                   wr_err, wr_skip, rd_err;
  logic [ADDR_WIDTH-1:0]  wr_addr, rd_addr;
  logic [SIZE_WIDTH-1:0]  wr_size, rd_size;
  logic [BURST_WIDTH-1:0] wr_burst, rd_burst;
  logic [IDX_W-1:0]       ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  function automatic logic req_bad(input logic [BURST_WIDTH-1:0] burst,
                                   input logic [SIZE_WIDTH-1:0]  size);
    return ((burst != BURST_WIDTH'(FIXED)) && (burst != BURST_WIDTH'(INCR))) ||
           (int'(size) > LSB);
  endfunction

  // Byte address -> word index; truncation is the modulo-MEM_DEPTH wrap.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> LSB);
  endfunction

  assign aw_hs       = axi_AWVALID && (wr_state == W_IDLE);
  assign w_hs        = axi_WVALID  && (wr_state == W_DATA);
  assign ar_hs       = axi_ARVALID && (rd_state == R_IDLE);
  assign r_hs        = axi_RREADY  && (rd_state == R_DATA);
  assign aw_bad      = req_bad(axi_AWBURST, axi_AWSIZE);
  assign ar_bad      = req_bad(axi_ARBURST, axi_ARSIZE);
  assign w_last_beat = (wr_beat_num == 32'(latched_awlen));
  assign axi_BRESP   = wr_err ? RESP_WIDTH'(SLVERR) : RESP_WIDTH'(OKAY);

  assign ram_waddr = word_idx(wr_addr);
  // Beat 0 is fetched straight from the AR address; later beats from rd_addr,
  // which always points at the beat after the one currently on R.
  assign ram_raddr = (rd_state == R_IDLE) ? word_idx(axi_ARADDR) : word_idx(rd_addr);

  axi_slave_ram #(
    .MEM_DEPTH  (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (axi_ACLK),
    .we    (w_hs && !wr_skip),
    .waddr (ram_waddr),
    .wstrb (axi_WSTRB),
    .wdata (axi_WDATA),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    axi_AWREADY  = 1'b0;
    axi_WREADY   = 1'b0;
    axi_BVALID   = 1'b0;
    unique case (wr_state)
      W_IDLE: begin
        axi_AWREADY = 1'b1;
        if (axi_AWVALID) wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        axi_WREADY = 1'b1;
        // Burst length is set by AWLEN alone; WLAST only feeds the error flag.
        if (axi_WVALID && w_last_beat) wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        axi_BVALID = 1'b1;
        if (axi_BREADY) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    axi_ARREADY  = 1'b0;
    axi_RVALID   = 1'b0;
    unique case (rd_state)
      R_IDLE: begin
        axi_ARREADY = 1'b1;
        if (axi_ARVALID) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        axi_RVALID = 1'b1;
        if (axi_RREADY && axi_RLAST) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) begin
      wr_beat_num   <= '0;
      latched_awlen <= '0;
      axi_BID       <= '0;
      wr_err        <= 1'b0;
      wr_skip       <= 1'b0;
    end else if (aw_hs) begin
      wr_beat_num   <= '0;
      latched_awlen <= axi_AWLEN;
      axi_BID       <= axi_AWID;
      wr_err        <= aw_bad;
      wr_skip       <= aw_bad;
    end else if (w_hs) begin
      wr_beat_num <= wr_beat_num + 32'd1;
      wr_err      <= wr_err | (axi_WLAST != w_last_beat);
    end
  end

  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) begin
      next_rd_beat_num <= '0;
      latched_arlen    <= '0;
      axi_RID          <= '0;
      axi_RDATA        <= '0;
      axi_RRESP        <= '0;
      axi_RLAST        <= 1'b0;
      rd_err           <= 1'b0;
    end else if (ar_hs) begin
      next_rd_beat_num <= '0;
      latched_arlen    <= axi_ARLEN;
      axi_RID          <= axi_ARID;
      axi_RDATA        <= ar_bad ? '0 : ram_rdata;
      axi_RRESP        <= ar_bad ? RESP_WIDTH'(SLVERR) : RESP_WIDTH'(OKAY);
      axi_RLAST        <= (axi_ARLEN == '0);
      rd_err           <= ar_bad;
    end else if (r_hs) begin
      if (axi_RLAST) begin
        axi_RLAST <= 1'b0;
      end else begin
        next_rd_beat_num <= next_rd_beat_num + 32'd1;
        axi_RDATA        <= rd_err ? '0 : ram_rdata;
        axi_RLAST        <= ((next_rd_beat_num + 32'd1) == 32'(latched_arlen));
      end
    end
  end

  // Burst address/size/kind: pure datapath, only meaningful after a handshake.
  always_ff @(posedge axi_ACLK) begin
    if (aw_hs) begin
      wr_addr  <= axi_AWADDR;
      wr_size  <= axi_AWSIZE;
      wr_burst <= axi_AWBURST;
    end else if (w_hs) begin
      wr_addr <= ADDR_WIDTH'(next_addr(64'(wr_addr), 8'(wr_size), 2'(wr_burst)));
    end
    if (ar_hs) begin
      rd_addr  <= ADDR_WIDTH'(next_addr(64'(axi_ARADDR), 8'(axi_ARSIZE), 2'(axi_ARBURST)));
      rd_size  <= axi_ARSIZE;
      rd_burst <= axi_ARBURST;
    end else if (r_hs && !axi_RLAST) begin
      rd_addr <= ADDR_WIDTH'(next_addr(64'(rd_addr), 8'(rd_size), 2'(rd_burst)));
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem (default parameters).
module tb_axi_slave_mem;

  logic        axi_ACLK = 1'b0;
  logic        axi_ARESETn;
  logic        axi_AWVALID, axi_AWREADY;
  logic [3:0]  axi_AWID;
  logic [15:0] axi_AWADDR;
  logic [7:0]  axi_AWLEN;
  logic [2:0]  axi_AWSIZE;
  logic [1:0]  axi_AWBURST;
  logic        axi_WVALID, axi_WREADY;
  logic [31:0] axi_WDATA;
  logic [3:0]  axi_WSTRB;
  logic        axi_WLAST;
  logic        axi_BVALID, axi_BREADY;
  logic [3:0]  axi_BID;
  logic [1:0]  axi_BRESP;
  logic        axi_ARVALID, axi_ARREADY;
  logic [3:0]  axi_ARID;
  logic [15:0] axi_ARADDR;
  logic [7:0]  axi_ARLEN;
  logic [2:0]  axi_ARSIZE;
  logic [1:0]  axi_ARBURST;
  logic        axi_RVALID, axi_RREADY;
  logic [3:0]  axi_RID;
  logic [31:0] axi_RDATA;
  logic [1:0]  axi_RRESP;
  logic        axi_RLAST;
  logic [31:0] wr_beat_num, next_rd_beat_num;
  logic [7:0]  latched_awlen, latched_arlen;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cap_data [16];
  logic        cap_last [16];
  logic [1:0]  cap_resp [16];
  logic [31:0] cap_beat [16];
  logic [3:0]  cap_id   [16];
  int          cap_wait [16];
  logic        cap_end_valid;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  always #5 axi_ACLK = ~axi_ACLK;

  axi_slave_mem dut (
    .axi_ACLK(axi_ACLK), .axi_ARESETn(axi_ARESETn),
    .axi_AWVALID(axi_AWVALID), .axi_AWREADY(axi_AWREADY), .axi_AWID(axi_AWID),
    .axi_AWADDR(axi_AWADDR), .axi_AWLEN(axi_AWLEN), .axi_AWSIZE(axi_AWSIZE),
    .axi_AWBURST(axi_AWBURST),
    .axi_WVALID(axi_WVALID), .axi_WREADY(axi_WREADY), .axi_WDATA(axi_WDATA),
    .axi_WSTRB(axi_WSTRB), .axi_WLAST(axi_WLAST),
    .axi_BVALID(axi_BVALID), .axi_BREADY(axi_BREADY), .axi_BID(axi_BID),
    .axi_BRESP(axi_BRESP),
    .axi_ARVALID(axi_ARVALID), .axi_ARREADY(axi_ARREADY), .axi_ARID(axi_ARID),
    .axi_ARADDR(axi_ARADDR), .axi_ARLEN(axi_ARLEN), .axi_ARSIZE(axi_ARSIZE),
    .axi_ARBURST(axi_ARBURST),
    .axi_RVALID(axi_RVALID), .axi_RREADY(axi_RREADY), .axi_RID(axi_RID),
    .axi_RDATA(axi_RDATA), .axi_RRESP(axi_RRESP), .axi_RLAST(axi_RLAST),
    .wr_beat_num(wr_beat_num), .next_rd_beat_num(next_rd_beat_num),
    .latched_awlen(latched_awlen), .latched_arlen(latched_arlen)
  );

  // ---------------- stimulus helpers (return just after the handshake edge)
  task automatic do_aw(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int cnt = 0;
    @(negedge axi_ACLK);
    axi_AWVALID = 1'b1; axi_AWID = id; axi_AWADDR = addr;
    axi_AWLEN = len; axi_AWSIZE = size; axi_AWBURST = burst;
    while (!axi_AWREADY && cnt < 50) begin @(negedge axi_ACLK); cnt++; end
    n_checks++;
    if (axi_AWREADY !== 1'b1) begin n_fail++; $display("FAIL aw_timeout: AWREADY=%b required 1", axi_AWREADY); end
    @(posedge axi_ACLK); #1 axi_AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int cnt = 0;
    @(negedge axi_ACLK);
    axi_WVALID = 1'b1; axi_WDATA = data; axi_WSTRB = strb; axi_WLAST = last;
    while (!axi_WREADY && cnt < 50) begin @(negedge axi_ACLK); cnt++; end
    n_checks++;
    if (axi_WREADY !== 1'b1) begin n_fail++; $display("FAIL w_timeout: WREADY=%b required 1", axi_WREADY); end
    @(posedge axi_ACLK); #1 axi_WVALID = 1'b0; axi_WLAST = 1'b0;
  endtask

  task automatic do_b();
    int cnt = 0;
    @(negedge axi_ACLK);
    axi_BREADY = 1'b1;
    while (!axi_BVALID && cnt < 50) begin @(negedge axi_ACLK); cnt++; end
    n_checks++;
    if (axi_BVALID !== 1'b1) begin n_fail++; $display("FAIL b_timeout: BVALID=%b required 1", axi_BVALID); end
    b_resp = axi_BRESP; b_id = axi_BID;
    @(posedge axi_ACLK); #1 axi_BREADY = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int cnt = 0;
    @(negedge axi_ACLK);
    axi_ARVALID = 1'b1; axi_ARID = id; axi_ARADDR = addr;
    axi_ARLEN = len; axi_ARSIZE = size; axi_ARBURST = burst;
    while (!axi_ARREADY && cnt < 50) begin @(negedge axi_ACLK); cnt++; end
    n_checks++;
    if (axi_ARREADY !== 1'b1) begin n_fail++; $display("FAIL ar_timeout: ARREADY=%b required 1", axi_ARREADY); end
    @(posedge axi_ACLK); #1 axi_ARVALID = 1'b0;
  endtask

  // Records n R beats with RREADY held high; cap_wait[i] is the number of
  // extra cycles waited for RVALID before beat i.
  task automatic rd_collect(input int n);
    int cnt;
    @(negedge axi_ACLK);
    axi_RREADY = 1'b1;
    for (int i = 0; i < n; i++) begin
      cnt = 0;
      while (!axi_RVALID && cnt < 20) begin @(negedge axi_ACLK); cnt++; end
      cap_wait[i] = cnt; cap_data[i] = axi_RDATA; cap_last[i] = axi_RLAST;
      cap_resp[i] = axi_RRESP; cap_beat[i] = next_rd_beat_num; cap_id[i] = axi_RID;
      @(negedge axi_ACLK);
    end
    cap_end_valid = axi_RVALID;
    axi_RREADY = 1'b0;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    axi_ARESETn = 1'b0;
    #12;
    n_checks++; if ({axi_AWREADY, axi_ARREADY} !== 2'b11) begin n_fail++; $display("FAIL reset_ready: AW/AR=%b required 11", {axi_AWREADY, axi_ARREADY}); end
    n_checks++; if ({axi_WREADY, axi_BVALID, axi_RVALID, axi_RLAST} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: W/B/R/RLAST=%b required 0000", {axi_WREADY, axi_BVALID, axi_RVALID, axi_RLAST}); end
    n_checks++; if ({axi_BID, axi_BRESP, axi_RID, axi_RRESP} !== 12'h000) begin n_fail++; $display("FAIL reset_ids: BID/BRESP/RID/RRESP=%h required 000", {axi_BID, axi_BRESP, axi_RID, axi_RRESP}); end
    n_checks++; if (axi_RDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", axi_RDATA); end
    n_checks++; if ({wr_beat_num, next_rd_beat_num, latched_awlen, latched_arlen} !== 80'h0) begin n_fail++; $display("FAIL reset_counters: wr=%0d rd=%0d awlen=%0d arlen=%0d required all 0", wr_beat_num, next_rd_beat_num, latched_awlen, latched_arlen); end
    @(negedge axi_ACLK); axi_ARESETn = 1'b1;
  endtask

  task automatic test_single();
    do_aw(4'h5, 16'h0010, 8'd0, 3'd2, 2'd1);
    n_checks++; if (wr_beat_num !== 32'd0) begin n_fail++; $display("FAIL single_beat0: got %0d required 0", wr_beat_num); end
    do_w(32'hDEADBEEF, 4'hF, 1'b1);
    n_checks++; if (wr_beat_num !== 32'd1) begin n_fail++; $display("FAIL single_beat1: got %0d required 1", wr_beat_num); end
    @(negedge axi_ACLK);
    n_checks++; if (axi_BVALID !== 1'b1) begin n_fail++; $display("FAIL single_bvalid: got %b required 1", axi_BVALID); end
    do_b();
    n_checks++; if ({b_id, b_resp} !== {4'h5, 2'b00}) begin n_fail++; $display("FAIL single_b: BID=%h BRESP=%b required 5/00", b_id, b_resp); end
    @(negedge axi_ACLK);
    n_checks++; if ({axi_AWREADY, axi_BVALID} !== 2'b10) begin n_fail++; $display("FAIL single_idle: AWREADY/BVALID=%b required 10", {axi_AWREADY, axi_BVALID}); end
    do_ar(4'h9, 16'h0010, 8'd0, 3'd2, 2'd1);
    rd_collect(1);
    n_checks++; if (cap_wait[0] !== 0) begin n_fail++; $display("FAIL single_rlat: waited %0d required 0", cap_wait[0]); end
    n_checks++; if (cap_data[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: got %h required deadbeef", cap_data[0]); end
    n_checks++; if ({cap_last[0], cap_id[0], cap_resp[0]} !== {1'b1, 4'h9, 2'b00}) begin n_fail++; $display("FAIL single_rside: RLAST=%b RID=%h RRESP=%b required 1/9/00", cap_last[0], cap_id[0], cap_resp[0]); end
    n_checks++; if (cap_end_valid !== 1'b0) begin n_fail++; $display("FAIL single_rend: RVALID=%b required 0", cap_end_valid); end
  endtask

  task automatic test_incr_burst();
    do_aw(4'h3, 16'h0100, 8'd3, 3'd2, 2'd1);
    n_checks++; if (latched_awlen !== 8'd3) begin n_fail++; $display("FAIL incr_awlen: got %0d required 3", latched_awlen); end
    for (int i = 0; i < 4; i++) begin
      do_w(32'(i + 1), 4'hF, i == 3);
      n_checks++; if (wr_beat_num !== 32'(i + 1)) begin n_fail++; $display("FAIL incr_wbeat%0d: got %0d required %0d", i, wr_beat_num, i + 1); end
    end
    do_b();
    n_checks++; if ({b_id, b_resp} !== {4'h3, 2'b00}) begin n_fail++; $display("FAIL incr_b: BID=%h BRESP=%b required 3/00", b_id, b_resp); end
    do_ar(4'h4, 16'h0100, 8'd3, 3'd2, 2'd1);
    n_checks++; if (latched_arlen !== 8'd3) begin n_fail++; $display("FAIL incr_arlen: got %0d required 3", latched_arlen); end
    rd_collect(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({cap_data[i], cap_last[i], cap_beat[i], cap_resp[i]} !== {32'(i + 1), i == 3, 32'(i), 2'b00})
        begin n_fail++; $display("FAIL incr_rbeat%0d: data=%h last=%b beat=%0d resp=%b required %h/%b/%0d/00", i, cap_data[i], cap_last[i], cap_beat[i], cap_resp[i], i + 1, i == 3, i); end
    end
    n_checks++; if (cap_end_valid !== 1'b0) begin n_fail++; $display("FAIL incr_rend: RVALID=%b required 0", cap_end_valid); end
  endtask

  task automatic test_strobe_fixed();
    do_aw(4'h1, 16'h0020, 8'd0, 3'd2, 2'd1);
    do_w(32'h11223344, 4'hF, 1'b1);
    do_b();
    do_aw(4'h2, 16'h0020, 8'd1, 3'd2, 2'd0);
    do_w(32'h000000AA, 4'h1, 1'b0);
    do_w(32'h0000BB00, 4'h2, 1'b1);
    do_b();
    n_checks++; if (b_resp !== 2'b00) begin n_fail++; $display("FAIL fixed_bresp: got %b required 00", b_resp); end
    do_ar(4'h2, 16'h0020, 8'd0, 3'd2, 2'd1);
    rd_collect(1);
    n_checks++; if (cap_data[0] !== 32'h1122BBAA) begin n_fail++; $display("FAIL fixed_rdata: got %h required 1122bbaa", cap_data[0]); end
  endtask

  task automatic test_backpressure();
    do_ar(4'h6, 16'h0100, 8'd3, 3'd2, 2'd1);
    @(negedge axi_ACLK);
    n_checks++; if ({axi_RVALID, axi_RDATA} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL bp_beat0: RVALID=%b RDATA=%h required 1/1", axi_RVALID, axi_RDATA); end
    axi_RREADY = 1'b1;
    @(negedge axi_ACLK);
    axi_RREADY = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_checks++; if ({axi_RVALID, axi_RDATA, axi_RLAST, next_rd_beat_num} !== {1'b1, 32'd2, 1'b0, 32'd1})
        begin n_fail++; $display("FAIL bp_hold%0d: RVALID=%b RDATA=%h RLAST=%b beat=%0d required 1/2/0/1", c, axi_RVALID, axi_RDATA, axi_RLAST, next_rd_beat_num); end
      if (c < 3) @(negedge axi_ACLK);
    end
    axi_RREADY = 1'b1;
    @(negedge axi_ACLK);
    n_checks++; if ({axi_RDATA, axi_RLAST, next_rd_beat_num} !== {32'd3, 1'b0, 32'd2}) begin n_fail++; $display("FAIL bp_beat2: RDATA=%h RLAST=%b beat=%0d required 3/0/2", axi_RDATA, axi_RLAST, next_rd_beat_num); end
    @(negedge axi_ACLK);
    n_checks++; if ({axi_RDATA, axi_RLAST, next_rd_beat_num} !== {32'd4, 1'b1, 32'd3}) begin n_fail++; $display("FAIL bp_beat3: RDATA=%h RLAST=%b beat=%0d required 4/1/3", axi_RDATA, axi_RLAST, next_rd_beat_num); end
    @(negedge axi_ACLK);
    n_checks++; if (axi_RVALID !== 1'b0) begin n_fail++; $display("FAIL bp_end: RVALID=%b required 0", axi_RVALID); end
    axi_RREADY = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] wd [3];
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;
    do_aw(4'h7, 16'h0200, 8'd2, 3'd2, 2'd1);
    for (int i = 0; i < 3; i++) begin
      do_w(wd[i], 4'hF, i == 0);
      if (i < 2) begin
        n_checks++; if ({axi_WREADY, axi_BVALID} !== 2'b10) begin n_fail++; $display("FAIL err_wcont%0d: WREADY/BVALID=%b required 10", i, {axi_WREADY, axi_BVALID}); end
      end
    end
    @(negedge axi_ACLK);
    n_checks++; if (axi_BVALID !== 1'b1) begin n_fail++; $display("FAIL err_bvalid: got %b required 1", axi_BVALID); end
    do_b();
    n_checks++; if ({b_id, b_resp} !== {4'h7, 2'b10}) begin n_fail++; $display("FAIL err_wlast_b: BID=%h BRESP=%b required 7/10", b_id, b_resp); end
    do_ar(4'h7, 16'h0200, 8'd2, 3'd2, 2'd1);
    rd_collect(3);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({cap_data[i], cap_resp[i]} !== {wd[i], 2'b00}) begin n_fail++; $display("FAIL err_wlast_rd%0d: data=%h resp=%b required %h/00", i, cap_data[i], cap_resp[i], wd[i]); end
    end
    do_aw(4'h8, 16'h0100, 8'd0, 3'd2, 2'd2);
    do_w(32'hFFFFFFFF, 4'hF, 1'b1);
    do_b();
    n_checks++; if (b_resp !== 2'b10) begin n_fail++; $display("FAIL err_wrap_b: BRESP=%b required 10", b_resp); end
    do_ar(4'hA, 16'h0100, 8'd3, 3'd2, 2'd2);
    rd_collect(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({cap_data[i], cap_resp[i], cap_last[i]} !== {32'h0, 2'b10, i == 3}) begin n_fail++; $display("FAIL err_wrap_rd%0d: data=%h resp=%b last=%b required 0/10/%b", i, cap_data[i], cap_resp[i], cap_last[i], i == 3); end
    end
    do_ar(4'hB, 16'h0100, 8'd0, 3'd2, 2'd1);
    rd_collect(1);
    n_checks++; if (cap_data[0] !== 32'd1) begin n_fail++; $display("FAIL err_wrap_nowrite: got %h required 1", cap_data[0]); end
    do_ar(4'hC, 16'h0100, 8'd0, 3'd3, 2'd1);
    rd_collect(1);
    n_checks++; if ({cap_data[0], cap_resp[0]} !== {32'h0, 2'b10}) begin n_fail++; $display("FAIL err_size_rd: data=%h resp=%b required 0/10", cap_data[0], cap_resp[0]); end
  endtask

  task automatic test_reset_mid_burst();
    do_aw(4'h2, 16'h0300, 8'd7, 3'd2, 2'd1);
    do_w(32'h55, 4'hF, 1'b0);
    do_w(32'h66, 4'hF, 1'b0);
    @(negedge axi_ACLK);
    axi_WVALID = 1'b1; axi_WDATA = 32'h77; axi_WSTRB = 4'hF;
    #2 axi_ARESETn = 1'b0;
    #1;
    n_checks++; if ({axi_AWREADY, axi_WREADY, axi_BVALID} !== 3'b100) begin n_fail++; $display("FAIL rst_mid_ctrl: AWREADY/WREADY/BVALID=%b required 100", {axi_AWREADY, axi_WREADY, axi_BVALID}); end
    n_checks++; if ({wr_beat_num, latched_awlen} !== 40'h0) begin n_fail++; $display("FAIL rst_mid_cnt: beat=%0d awlen=%0d required 0/0", wr_beat_num, latched_awlen); end
    axi_WVALID = 1'b0;
    @(negedge axi_ACLK); axi_ARESETn = 1'b1;
    do_aw(4'h3, 16'h0308, 8'd0, 3'd2, 2'd1);
    do_w(32'h99, 4'hF, 1'b1);
    do_b();
    n_checks++; if ({b_id, b_resp} !== {4'h3, 2'b00}) begin n_fail++; $display("FAIL rst_mid_newb: BID=%h BRESP=%b required 3/00", b_id, b_resp); end
    do_ar(4'h1, 16'h0300, 8'd2, 3'd2, 2'd1);
    rd_collect(3);
    n_checks++; if ({cap_data[0], cap_data[1], cap_data[2]} !== {32'h55, 32'h66, 32'h99}) begin n_fail++; $display("FAIL rst_mid_ram: got %h %h %h required 55 66 99", cap_data[0], cap_data[1], cap_data[2]); end
  endtask

  initial begin
    axi_ARESETn = 1'b0;
    axi_AWVALID = 1'b0; axi_AWID = '0; axi_AWADDR = '0; axi_AWLEN = '0; axi_AWSIZE = '0; axi_AWBURST = '0;
    axi_WVALID = 1'b0; axi_WDATA = '0; axi_WSTRB = '0; axi_WLAST = 1'b0;
    axi_BREADY = 1'b0;
    axi_ARVALID = 1'b0; axi_ARID = '0; axi_ARADDR = '0; axi_ARLEN = '0; axi_ARSIZE = '0; axi_ARBURST = '0;
    axi_RREADY = 1'b0;
    test_reset();
    test_single();
    test_incr_burst();
    test_strobe_fixed();
    test_backpressure();
    test_errors();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

endmodule
